// File: rtl/dp_seq_arb_if.sv
// Bus bundle between the instruction requesters, dp_seq_arb and the datapath.
// master = sequencer side; slave = requesters plus datapath side; state is a debug view of the FSM.
interface dp_seq_arb_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req;
    logic [16*NREQ-1:0]   ins;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [31:0]          res_data;
    logic                 busy;
    logic                 dp_rd1;
    logic                 dp_rd2;
    logic                 dp_wr;
    logic [3:0]           dp_opcode;
    logic [3:0]           dp_src1;
    logic [3:0]           dp_src2;
    logic [3:0]           dp_dest;
    logic [31:0]          dp_out_data;
    logic [2:0]           state;

    // req is a level: an operation is issued only if req is high when sampled in IDLE;
    // gnt stays high from grant through DONE and done pulses once to acknowledge it.
    modport master (
        input  req, ins, dp_out_data,
        output gnt, done, res_data, busy, dp_rd1, dp_rd2, dp_wr,
               dp_opcode, dp_src1, dp_src2, dp_dest, state
    );
    modport slave (
        output req, ins, dp_out_data,
        input  gnt, done, res_data, busy, dp_rd1, dp_rd2, dp_wr,
               dp_opcode, dp_src1, dp_src2, dp_dest, state
    );
endinterface

// File: rtl/dp_seq_arb.sv
// Arbitrates requesters and sequences the datapath through READ/EXEC/WRITE/DONE.
// Define DP_SEQ_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module dp_seq_arb #(
    parameter int NREQ     = 2,
    parameter int EXEC_CYC = 1
) (
    input  logic         clk,
    input  logic         rst,
    dp_seq_arb_if.master bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              run;
    logic [3:0]        cnt;
    logic              any_req;
    logic [IW-1:0]     win_idx;
    logic [NREQ-1:0]   win_oh;
    logic [15:0]       win_ins;

`ifdef DP_SEQ_ARB_RR_EN
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     gnt_idx;
`endif

    assign bus.state = state;

    // Reset release passes through one flop so the first grant lands on the second edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run <= 1'b0;
        else      run <= 1'b1;
    end

    always_comb begin
`ifdef DP_SEQ_ARB_RR_EN
        int j;
        j = 0;
`endif
        win_idx = '0;
        any_req = 1'b0;
`ifdef DP_SEQ_ARB_RR_EN
        // Walk backwards so the last hit is the first requester at or after ptr.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (bus.req[j]) begin
                win_idx = IW'(j);
                any_req = 1'b1;
            end
        end
`else
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win_idx = IW'(i);
                any_req = 1'b1;
            end
        end
`endif
        win_oh  = NREQ'(1) << win_idx;
        win_ins = bus.ins[16*int'(win_idx) +: 16];
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (run && any_req) state_next = S_READ;
            S_READ:  state_next = S_EXEC;
            S_EXEC:  if (cnt == 4'(EXEC_CYC - 1)) state_next = S_WRITE;
            S_WRITE: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Strobes and status are decoded from the next state so every output is a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.dp_rd1   <= 1'b0;
            bus.dp_rd2   <= 1'b0;
            bus.dp_wr    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= '0;
            bus.res_data <= '0;
            cnt          <= '0;
        end else begin
            bus.dp_rd1 <= (state_next == S_READ);
            bus.dp_rd2 <= (state_next == S_READ);
            bus.dp_wr  <= (state_next == S_WRITE);
            bus.busy   <= (state_next != S_IDLE);
            bus.done   <= (state_next == S_DONE) ? bus.gnt : '0;
            if (state == S_READ)       cnt <= '0;
            else if (state == S_EXEC)  cnt <= cnt + 4'd1;
            if (state == S_WRITE)      bus.res_data <= bus.dp_out_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.gnt       <= '0;
            bus.dp_opcode <= '0;
            bus.dp_src1   <= '0;
            bus.dp_src2   <= '0;
            bus.dp_dest   <= '0;
`ifdef DP_SEQ_ARB_RR_EN
            ptr           <= '0;
            gnt_idx       <= '0;
`endif
        end else if (state == S_IDLE && state_next == S_READ) begin
            bus.gnt       <= win_oh;
            bus.dp_opcode <= win_ins[15:12];
            bus.dp_src1   <= win_ins[11:8];
            bus.dp_src2   <= win_ins[7:4];
            bus.dp_dest   <= win_ins[3:0];
`ifdef DP_SEQ_ARB_RR_EN
            gnt_idx       <= win_idx;
`endif
        end else if (state == S_DONE) begin
            bus.gnt       <= '0;
            bus.dp_opcode <= '0;
            bus.dp_src1   <= '0;
            bus.dp_src2   <= '0;
            bus.dp_dest   <= '0;
`ifdef DP_SEQ_ARB_RR_EN
            ptr           <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
`endif
        end
    end
endmodule

// File: tb/tb_dp_seq_arb.sv
// Self-checking bench for dp_seq_arb: one EXEC_CYC=1 instance with a done/result scoreboard,
// one EXEC_CYC=15 instance for phase timing; expectations follow DP_SEQ_ARB_RR_EN.
module tb_dp_seq_arb;
    localparam int NREQ = 2;
    localparam int W    = NREQ + 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dp_seq_arb_if #(.NREQ(NREQ)) a ();
    dp_seq_arb_if #(.NREQ(NREQ)) b ();

    dp_seq_arb #(.NREQ(NREQ), .EXEC_CYC(1))  dut      (.clk(clk), .rst(rst), .bus(a.master));
    dp_seq_arb #(.NREQ(NREQ), .EXEC_CYC(15)) dut_long (.clk(clk), .rst(rst), .bus(b.master));

    // Datapath model: result exists only while dp_wr is high.
    logic [31:0] dp_base;
    assign a.dp_out_data = a.dp_wr ? (dp_base ^ {16'h0, a.dp_opcode, a.dp_src1, a.dp_src2, a.dp_dest}) : 32'h0;
    assign b.dp_out_data = b.dp_wr ? (dp_base ^ {16'h0, b.dp_opcode, b.dp_src1, b.dp_src2, b.dp_dest}) : 32'h0;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    logic         mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [W-1:0] mk_exp(input int idx, input logic [15:0] word);
        return {NREQ'(1 << idx), dp_base ^ {16'h0, word}};
    endfunction

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (a.done == '0 && k < budget) begin
            cyc(1);
            k++;
        end
        check(tag, 32'(a.done != '0), 32'd1);
    endtask

    // Scoreboard and invariants on the main instance.
    always @(negedge clk) begin
        if (rst && mon_en) begin
            check("gnt_onehot0", 32'($onehot0(a.gnt)), 32'd1);
            check("rd_wr_excl", 32'(a.dp_rd1 & a.dp_wr), 32'd0);
            if (|a.done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'(a.done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_done_vec", 32'(a.done), 32'(e[W-1:32]));
                    check("sb_res_data", a.res_data, e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NREQ-1:0] exp_g[4];
        int wr_at, wr_cnt, rd_at, rd_cnt, done_at, exec_strb;
        logic [31:0] long_res;

        a.req = '0; a.ins = '0; b.req = '0; b.ins = '0;
        dp_base = 32'hDEADBEEF ^ 32'h0000_3125;
        rst = 1'b0;
        cyc(2);

        check("rst_gnt", 32'(a.gnt), 0);
        check("rst_busy", 32'(a.busy), 0);
        check("rst_done", 32'(a.done), 0);
        check("rst_res", a.res_data, 0);
        check("rst_fields", 32'({a.dp_opcode, a.dp_src1, a.dp_src2, a.dp_dest}), 0);
        check("rst_strobes", 32'({a.dp_rd1, a.dp_rd2, a.dp_wr}), 0);
        check("rst_long_busy", 32'(b.busy), 0);

        // Release with req already high: the grant must wait for the second edge.
        a.ins[15:0] = 16'h3125;
        a.req = 2'b01;
        exp_q.push_back(mk_exp(0, 16'h3125));
        rst = 1'b1;
        mon_en = 1'b1;
        cyc(1);
        check("rel_edge1_gnt", 32'(a.gnt), 0);
        cyc(1);
        check("op1_gnt", 32'(a.gnt), 32'h1);
        check("op1_busy", 32'(a.busy), 1);
        check("op1_rd_t1", 32'({a.dp_rd1, a.dp_rd2, a.dp_wr}), 32'b110);
        check("op1_fields", 32'({a.dp_opcode, a.dp_src1, a.dp_src2, a.dp_dest}), 32'h3125);
        a.req = '0;
        cyc(1);
        check("op1_exec_strb", 32'({a.dp_rd1, a.dp_rd2, a.dp_wr}), 0);
        cyc(1);
        check("op1_wr_t3", 32'({a.dp_rd1, a.dp_rd2, a.dp_wr}), 32'b001);
        cyc(1);
        check("op1_done_t4", 32'(a.done), 32'h1);
        check("op1_res_t4", a.res_data, 32'hDEADBEEF);
        cyc(1);
        check("op1_idle_gnt", 32'(a.gnt), 0);
        check("op1_idle_busy", 32'(a.busy), 0);
        check("op1_res_hold", a.res_data, 32'hDEADBEEF);
        check("op1_idle_fields", 32'({a.dp_opcode, a.dp_src1, a.dp_src2, a.dp_dest}), 0);

        // Requester 1 alone.
        a.ins[31:16] = 16'h9ABC;
        a.req = 2'b10;
        exp_q.push_back(mk_exp(1, 16'h9ABC));
        cyc(1);
        check("op2_gnt", 32'(a.gnt), 32'h2);
        check("op2_fields", 32'({a.dp_opcode, a.dp_src1, a.dp_src2, a.dp_dest}), 32'h9ABC);
        a.req = '0;
        wait_done("op2_done_seen", 8);
        cyc(1);

        // Instruction and req change during EXEC must not disturb the operation.
        a.ins[15:0] = 16'h4A6B;
        a.req = 2'b01;
        exp_q.push_back(mk_exp(0, 16'h4A6B));
        cyc(1);
        check("stab_gnt", 32'(a.gnt), 32'h1);
        cyc(1);
        a.ins[15:0] = 16'hFFFF;
        a.req = '0;
        cyc(1);
        check("stab_fields_wr", 32'({a.dp_opcode, a.dp_src1, a.dp_src2, a.dp_dest}), 32'h4A6B);
        check("stab_wr", 32'(a.dp_wr), 1);
        cyc(1);
        check("stab_done", 32'(a.done), 32'h1);
        cyc(1);

        // A req pulse that never sees a sampling edge issues nothing.
        a.req = 2'b01;
        #2;
        a.req = '0;
        cyc(1);
        check("drop_gnt", 32'(a.gnt), 0);
        cyc(1);
        check("drop_busy", 32'(a.busy), 0);

        // Reset mid-EXEC with requester 1 granted.
        a.ins[31:16] = 16'h2468;
        a.req = 2'b10;
        cyc(1);
        a.req = '0;
        cyc(1);
        check("mid_gnt_exec", 32'(a.gnt), 32'h2);
        rst = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(a.gnt), 0);
        check("mid_rst_busy", 32'(a.busy), 0);
        check("mid_rst_strb", 32'({a.dp_rd1, a.dp_rd2, a.dp_wr}), 0);
        check("mid_rst_res", a.res_data, 0);
        cyc(1);
        rst = 1'b1;
        cyc(3);
        check("post_rst_idle_gnt", 32'(a.gnt), 0);
        check("post_rst_idle_busy", 32'(a.busy), 0);

        // Contention with both requesters held.
`ifdef DP_SEQ_ARB_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        a.ins = {16'h5B2D, 16'h1E0F};
        for (int n = 0; n < 4; n++)
            exp_q.push_back(exp_g[n] == 2'b01 ? mk_exp(0, 16'h1E0F) : mk_exp(1, 16'h5B2D));
        exp_q.push_back(mk_exp(1, 16'h5B2D));
        a.req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            cyc(1);
            check("cont_gnt", 32'(a.gnt), 32'(exp_g[n]));
            wait_done("cont_done_seen", 8);
            if (n == 3) a.req = 2'b10;
            cyc(1);
            check("cont_idle_gap", 32'(a.gnt), 0);
        end
        cyc(1);
        check("cont_req1_gnt", 32'(a.gnt), 32'h2);
        a.req = '0;
        wait_done("cont_req1_done_seen", 8);
        cyc(2);

        // Long execute phase on the EXEC_CYC=15 instance.
        wr_at = 0; wr_cnt = 0; rd_at = 0; rd_cnt = 0; done_at = 0; exec_strb = 0; long_res = '0;
        b.ins[15:0] = 16'h7E81;
        b.req = 2'b01;
        for (int c = 1; c <= 20; c++) begin
            cyc(1);
            if (c == 1) b.req = '0;
            if (b.dp_wr) begin wr_cnt++; wr_at = c; end
            if (b.dp_rd1 | b.dp_rd2) begin rd_cnt++; rd_at = c; end
            if (c >= 2 && c <= 16 && (b.dp_rd1 | b.dp_rd2 | b.dp_wr)) exec_strb++;
            if (|b.done) begin done_at = c; long_res = b.res_data; end
        end
        check("long_rd_at", 32'(rd_at), 1);
        check("long_rd_cnt", 32'(rd_cnt), 1);
        check("long_wr_at", 32'(wr_at), 17);
        check("long_wr_cnt", 32'(wr_cnt), 1);
        check("long_exec_strobes", 32'(exec_strb), 0);
        check("long_done_at", 32'(done_at), 18);
        check("long_res", long_res, dp_base ^ 32'h7E81);
        check("long_idle_gnt", 32'(b.gnt), 0);

        check("exp_q_empty", 32'(exp_q.size()), 0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dp_seq_arb.md
# dp_seq_arb

Sequencer and arbiter for the register-file/ALU datapath. Several requesters each present a 16-bit instruction: opcode[15:12], src1[11:8], src2[7:4], dest[3:0]. The block grants one requester at a time and latches its instruction. It steps the datapath through read, execute and write phases using the Rd1/Rd2/Wr strobes, then returns the datapath result to the granted requester. It sits between the instruction sources and `data_path`, replacing a direct strobe drive.

## Interface
- NREQ, 2: number of requesters; legal range 2..4.
- EXEC_CYC, 1: number of execute-phase cycles; legal range 1..15.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- req  in  NREQ  per-requester operation request, level.
- ins  in  16*NREQ  instruction for requester i on bits [16*i+15:16*i].
- gnt  out  NREQ  one-hot grant; held from grant through DONE.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- res_data  out  32  datapath result; valid in the cycle `done` pulses, held until the next capture.
- busy  out  1  high whenever state is not IDLE.
- dp_rd1, dp_rd2, dp_wr  out  1 each  datapath read and write strobes.
- dp_opcode, dp_src1, dp_src2, dp_dest  out  4 each  latched instruction fields.
- dp_out_data  in  32  datapath result bus.

## Operation
- States: IDLE → READ → EXEC → WRITE → DONE → IDLE. No other transitions exist.
- **IDLE**
  - If any req bit is high, select a winner; see Configuration for the selection rule.
  - Register the one-hot `gnt` and latch that requester's instruction into the dp_* field registers.
  - Go to READ.
  - If no req bit is high, stay in IDLE with all dp_* outputs 0.
- **READ**: dp_rd1 = dp_rd2 = 1 for exactly one cycle. Clear the exec counter.
- **EXEC**
  - Strobes are 0. The 4-bit counter increments each cycle.
  - Leave for WRITE when count == EXEC_CYC-1.
- **WRITE**
  - dp_wr = 1 for exactly one cycle.
  - Capture dp_out_data into res_data at the end of this cycle.
- **DONE**
  - Pulse `done` on the granted requester's bit.
  - Clear `gnt` and the dp_* field registers on exit. Update the priority pointer.
- Instruction fields are sampled only at grant. Changes to `ins` or `req` after the grant do not affect the operation in flight.
- If a requester drops `req` after being granted, its operation still completes and `done` still pulses.
- If `req` is dropped before a grant, no operation is issued for that requester.
- A requester that holds `req` high through its own `done` is re-arbitrated in the following IDLE cycle. It does not get an implicit back-to-back grant.
- Reset asserted mid-operation: immediately return to IDLE. All outputs go to 0, and res_data goes to 0. The priority pointer goes to 0. The partial operation is lost.
- At most one of dp_rd1/dp_wr is ever high. `gnt` is always one-hot or zero.

## Timing
- All outputs are registered.
- Reset values: every output is 0; state = IDLE; pointer = 0.
- Let req be sampled high in IDLE at edge t. Then:
  - gnt and busy are high from t+1.
  - READ is cycle t+1.
  - EXEC covers cycles t+2 .. t+1+EXEC_CYC.
  - WRITE is cycle t+2+EXEC_CYC.
  - DONE (done pulse, res_data valid) is cycle t+3+EXEC_CYC.
- Request-to-done latency = EXEC_CYC + 3 cycles after the grant edge.
- Minimum spacing between grants is EXEC_CYC + 4 cycles, because of one mandatory IDLE cycle.
- Release of the reset deassertion is synchronous to clk, so the first grant occurs no earlier than the second rising edge after release.

## Configuration
- Macro: `DP_SEQ_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - Search starts at the pointer index and goes upward, wrapping at NREQ-1 to 0.
  - After DONE, the pointer becomes (granted index + 1) mod NREQ.
- Not defined: fixed priority.
  - The lowest asserted req index always wins.
  - The pointer register is not built.

## Test plan
- **Reset**: rst=0 mid-EXEC with gnt=2'b10 → next sample shows gnt=0, dp_rd1/dp_wr=0, busy=0, res_data=0. After release, idle until a req is seen.
- **Single op**: NREQ=2, EXEC_CYC=1, req=2'b01, ins[15:0]=16'h3125, dp_out_data=32'hDEADBEEF in WRITE →
  - dp_opcode=3, src1=1, src2=2, dest=5;
  - rd strobes in cycle t+1, wr in cycle t+3;
  - done=2'b01 and res_data=32'hDEADBEEF at cycle t+4.
- **Long exec**: EXEC_CYC=15 → dp_wr exactly at t+17, done at t+18; no strobe during EXEC.
- **Contention, RR_EN defined**: req=2'b11 held continuously → grants alternate 01, 10, 01, 10, with one IDLE cycle between done and the next gnt.
- **Contention, RR_EN undefined**: req=2'b11 held → every grant is 2'b01. When req0 is then dropped, requester 1 is served.
- **Input stability**: change ins[15:0] to 16'hFFFF and drop req during EXEC → dp_* fields unchanged, done still pulses for that requester.
